// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   - opcode encodings and instruction field positions
//   - fetch FSM state type
//   - pre-decode flag type and the helper that computes it from an opcode
package instr_fetch_queue_pkg;

    // Opcode encodings (instruction bits [3:0])
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;
    localparam logic [3:0] OP_LW  = 4'h6;
    localparam logic [3:0] OP_SW  = 4'h7;
    localparam logic [3:0] OP_BEQ = 4'h8;
    localparam logic [3:0] OP_BGT = 4'h9;
    localparam logic [3:0] OP_BGE = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;

    // Instruction field positions
    localparam int OFFSET_MSB = 31;
    localparam int OFFSET_LSB = 19;
    localparam int RA_MSB     = 18;
    localparam int RA_LSB     = 14;
    localparam int RB_MSB     = 13;
    localparam int RB_LSB     = 9;
    localparam int RD_MSB     = 8;
    localparam int RD_LSB     = 4;
    localparam int OPCODE_MSB = 3;
    localparam int OPCODE_LSB = 0;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_REQ_KILL,
        FETCH_WAIT_KILL
    } fetch_state_e;

    typedef struct packed {
        logic is_branch;
        logic is_mem;
    } predecode_t;

    function automatic predecode_t predecode(input logic [3:0] opcode);
        predecode_t flags;
        flags.is_branch = (opcode == OP_BEQ) || (opcode == OP_BGT) || (opcode == OP_BGE);
        flags.is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
        return flags;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// DEPTH-entry synchronous FIFO used as the instruction prefetch buffer.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empties the FIFO at the next edge (wins over push)
//   push_i/push_data_i  write an entry (ignored when full)
//   pop_i           retire the head entry (ignored when empty)
//   head_o          current head entry (combinational read of the array)
//   count_o, full_o, empty_o  occupancy status
module instr_fetch_queue_fetch_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with prefetch buffer.
// Fetches sequential words over a req/gnt/rvalid memory handshake (one
// request outstanding at most), buffers up to DEPTH instructions with
// pre-decode flags, and hands them to decode over valid/ready. A redirect
// flushes the buffer, drops any in-flight response and refetches.
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i  instruction memory port
//   redirect_i, redirect_pc_i              branch redirect
//   instr_valid_o/ready_i/instr_o/instr_pc_o  decode port
//   instr_is_branch_o, instr_is_mem_o      stored pre-decode flags of head
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter int                   ADDRWIDTH = 16,
    parameter int                   DEPTH     = 4,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 imem_req_o,
    output logic [ADDRWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [ADDRWIDTH-1:0] redirect_pc_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [ADDRWIDTH-1:0] instr_pc_o,
    output logic                 instr_is_branch_o,
    output logic                 instr_is_mem_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Entry widths follow the module parameters, so the type lives here.
    typedef struct packed {
        logic [DATAWIDTH-1:0] instr;
        logic [ADDRWIDTH-1:0] pc;
        predecode_t           flags;
    } fetch_entry_t;

    fetch_state_e         state_q, state_d;
    logic                 imem_req_q, imem_req_d;
    logic [ADDRWIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [ADDRWIDTH-1:0] fetch_pc_q, fetch_pc_d;

    fetch_entry_t         push_entry, head_entry;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 credit;

    // Flags are computed once, at push time, and stored with the entry.
    always_comb begin
        push_entry.instr = imem_rdata_i;
        push_entry.pc    = imem_addr_q;
        push_entry.flags = predecode(imem_rdata_i[OPCODE_MSB:OPCODE_LSB]);
    end

    instr_fetch_queue_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign instr_valid_o     = ~fifo_empty;
    assign fifo_pop          = instr_valid_o & instr_ready_i;
    assign instr_o           = instr_valid_o ? head_entry.instr : '0;
    assign instr_pc_o        = instr_valid_o ? head_entry.pc : '0;
    assign instr_is_branch_o = instr_valid_o & head_entry.flags.is_branch;
    assign instr_is_mem_o    = instr_valid_o & head_entry.flags.is_mem;

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = imem_addr_q;

    // Requests are only launched from IDLE, where nothing is outstanding,
    // so the credit test reduces to the occupancy after this cycle's pop.
    assign credit = (fifo_count - CW'(fifo_pop)) < CW'(DEPTH);

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        fifo_push   = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (!redirect_i && credit) begin
                    state_d     = FETCH_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end
            end
            FETCH_REQ: begin
                if (imem_gnt_i) begin
                    imem_req_d = 1'b0;
                    fetch_pc_d = fetch_pc_q + ADDRWIDTH'(1);
                    state_d    = redirect_i ? FETCH_WAIT_KILL : FETCH_WAIT;
                end else if (redirect_i) begin
                    // The request must stay stable until granted.
                    state_d = FETCH_REQ_KILL;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d   = FETCH_IDLE;
                    fifo_push = ~redirect_i & ~fifo_full;
                end else if (redirect_i) begin
                    state_d = FETCH_WAIT_KILL;
                end
            end
            FETCH_REQ_KILL: begin
                if (imem_gnt_i) begin
                    imem_req_d = 1'b0;
                    state_d    = FETCH_WAIT_KILL;
                end
            end
            FETCH_WAIT_KILL: begin
                if (imem_rvalid_i) state_d = FETCH_IDLE;
            end
            default: begin
                state_d    = FETCH_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
        // A redirect always wins over the sequential increment.
        if (redirect_i) fetch_pc_d = redirect_pc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FETCH_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            fetch_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int             DW       = 32;
    localparam int             AW       = 16;
    localparam int             DEPTH    = 4;
    localparam logic [AW-1:0]  RESET_PC = '0;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_is_branch_o;
    logic          instr_is_mem_o;

    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(
        .DATAWIDTH (DW), .ADDRWIDTH (AW), .DEPTH (DEPTH), .RESET_PC (RESET_PC)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .imem_req_o (imem_req_o), .imem_addr_o (imem_addr_o),
        .imem_gnt_i (imem_gnt_i), .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i (redirect_i), .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o), .instr_ready_i (instr_ready_i),
        .instr_o (instr_o), .instr_pc_o (instr_pc_o),
        .instr_is_branch_o (instr_is_branch_o), .instr_is_mem_o (instr_is_mem_o)
    );

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
        logic          br;
        logic          mem;
    } exp_t;

    exp_t          exp_q[$];
    logic [1:0]    pop_flags[$];
    logic [DW-1:0] imem [256];
    int            n_cmp = 0;
    int            n_err = 0;

    // Reference model state: next fetch address and the single open fetch.
    logic [AW-1:0] model_pc = RESET_PC;
    logic          p_active = 0, p_granted = 0, p_killed = 0;
    logic [AW-1:0] p_addr = '0;
    int            p_delay = 0, p_stall = 0, p_wait = 0;
    int            push_now = 0, pop_count = 0, req_count = 0;
    logic [AW-1:0] last_req_addr = '0;

    // Stimulus knobs
    int            k_gnt_pct = 100, k_min_delay = 1, k_max_delay = 1;
    int            k_ready_pct = 100, k_redir_pct = 0, k_stray_pct = 0;
    int            k_gnt_stall = 0;
    logic          k_force_redir = 0;
    logic [AW-1:0] k_redir_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic ref_branch(input logic [DW-1:0] w);
        logic [3:0] op;
        op = w[3:0];
        return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BGE);
    endfunction

    function automatic logic ref_mem(input logic [DW-1:0] w);
        logic [3:0] op;
        op = w[3:0];
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // One clock of memory responder, decode driver and reference model.
    task automatic cycle();
        logic          req, gnt, rv, stray, redir;
        logic [AW-1:0] addr, rpc;
        @(negedge clk_i);
        push_now = 0;
        req  = imem_req_o;
        addr = imem_addr_o;
        gnt = 0; rv = 0; stray = 0;
        if (p_active && p_granted) begin
            if (p_delay <= 1) rv = 1;
            else p_delay--;
        end
        if (req) begin
            if (!p_active) begin
                chk("req_addr", addr, model_pc);
                chk("req_credit", exp_q.size() < DEPTH, 1);
                p_active = 1; p_granted = 0; p_killed = 0; p_addr = model_pc;
                p_stall = k_gnt_stall; k_gnt_stall = 0; p_wait = 0;
                req_count++;
                last_req_addr = addr;
            end else begin
                chk("addr_hold", addr, p_addr);
                chk("req_after_gnt", p_granted, 0);
            end
            if (!p_granted) begin
                if (p_stall > 0) p_stall--;
                else gnt = ($urandom_range(99) < k_gnt_pct) || (p_wait >= 6);
                p_wait++;
            end
        end else if (p_active && !p_granted) begin
            chk("req_held", req, 1);
        end
        if (!rv && !(p_active && p_granted) && ($urandom_range(99) < k_stray_pct)) stray = 1;
        redir = k_force_redir || ($urandom_range(99) < k_redir_pct);
        if (k_force_redir) rpc = k_redir_pc;
        else rpc = ($urandom_range(7) == 0) ? 16'hFFFE : 16'($urandom);
        k_force_redir = 0;

        imem_gnt_i    = gnt;
        imem_rvalid_i = rv | stray;
        imem_rdata_i  = rv ? imem[p_addr[7:0]] : DW'($urandom);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = ($urandom_range(99) < k_ready_pct);

        if (gnt) begin
            p_granted = 1;
            p_delay   = $urandom_range(k_max_delay, k_min_delay);
            if (!p_killed) model_pc = p_addr + 16'd1;
        end
        if (redir) begin
            model_pc = rpc;
            if (p_active) p_killed = 1;
        end
        if (rv) begin
            if (!p_killed && !redir) begin
                exp_q.push_back('{instr: imem[p_addr[7:0]], pc: p_addr,
                                  br: ref_branch(imem[p_addr[7:0]]),
                                  mem: ref_mem(imem[p_addr[7:0]])});
                push_now = 1;
            end
            p_active = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; instr_ready_i = 0;
        exp_q.delete(); pop_flags.delete();
        model_pc = RESET_PC; p_active = 0; p_granted = 0; p_killed = 0;
        push_now = 0; pop_count = 0; req_count = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_flags", {instr_is_branch_o, instr_is_mem_o}, 0);
        rst_ni = 1;
    endtask

    // Monitor: compares every accepted instruction against the scoreboard.
    always begin
        exp_t e;
        @(negedge clk_i);
        #1;
        if (rst_ni) begin
            chk("valid", instr_valid_o, (exp_q.size() - push_now) > 0);
            if (instr_valid_o && instr_ready_i) begin
                pop_count++;
                pop_flags.push_back({instr_is_branch_o, instr_is_mem_o});
                $display("[%0t] pop pc=0x%04h instr=0x%08h br=%0b mem=%0b",
                         $time, instr_pc_o, instr_o, instr_is_branch_o, instr_is_mem_o);
                if (exp_q.size() > push_now) begin
                    e = exp_q.pop_front();
                    chk("instr", instr_o, e.instr);
                    chk("pc", instr_pc_o, e.pc);
                    chk("is_branch", instr_is_branch_o, e.br);
                    chk("is_mem", instr_is_mem_o, e.mem);
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc 0x%0h with nothing expected", instr_pc_o);
                end
            end
            if (redirect_i) exp_q.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        for (int j = 0; j < 256; j++) imem[j] = $urandom;
        imem[0] = 32'h0000_4310;

        // Basic streaming: gnt same cycle, rvalid next cycle, ready high.
        do_reset();
        cycle();
        chk("first_req_cycle", req_count, 1);
        cycle(); cycle();
        #2 chk("first_instr", instr_o, 32'h0000_4310);
        repeat (9) cycle();
        #2 chk("throughput_pops", pop_count, 4);

        // Fill with decode stalled, then drain.
        do_reset();
        k_ready_pct = 0;
        repeat (20) cycle();
        chk("fill_reqs", req_count, 4);
        #2 chk("fill_no_req", imem_req_o, 0);
        chk("fill_valid", instr_valid_o, 1);
        k_ready_pct = 100;
        repeat (20) cycle();
        chk("refill_req", req_count > 4, 1);

        // Redirect while waiting for a response.
        do_reset();
        k_ready_pct = 0; k_min_delay = 3; k_max_delay = 3;
        for (i = 0; i < 40 && !(req_count == 3 && p_granted); i++) cycle();
        if (!(req_count == 3 && p_granted)) fail("wait_third_gnt");
        k_force_redir = 1; k_redir_pc = 16'h0040;
        cycle();
        cycle();
        #2 chk("redir_empty", instr_valid_o, 0);
        for (i = 0; i < 20 && req_count < 4; i++) cycle();
        chk("redir_next_addr", last_req_addr, 16'h0040);
        k_min_delay = 1; k_max_delay = 1; k_ready_pct = 100;

        // Redirect while the request is stalled for 3 cycles.
        k_gnt_stall = 3;
        do_reset();
        k_force_redir = 1; k_redir_pc = 16'h0080;
        cycle();
        for (i = 0; i < 20 && req_count < 2; i++) cycle();
        chk("stall_redir_addr", last_req_addr, 16'h0080);

        // Pre-decode flags.
        imem[0] = {28'h0012345, OP_BEQ};
        imem[1] = {28'h0000A11, OP_LW};
        imem[2] = {28'h0000431, OP_ADD};
        do_reset();
        repeat (12) cycle();
        if (pop_flags.size() >= 3) begin
            chk("flags_beq", pop_flags[0], 2'b10);
            chk("flags_lw", pop_flags[1], 2'b01);
            chk("flags_add", pop_flags[2], 2'b00);
        end else fail("flags_pops");

        // Asynchronous reset in the middle of a fetch.
        k_ready_pct = 0; k_min_delay = 3; k_max_delay = 3;
        do_reset();
        for (i = 0; i < 20 && !(req_count == 2 && p_granted); i++) cycle();
        cycle();
        #2 chk("pre_rst_valid", instr_valid_o, 1);
        rst_ni = 0;
        #1;
        chk("async_req", imem_req_o, 0);
        chk("async_valid", instr_valid_o, 0);
        chk("async_instr", instr_o, 0);
        chk("async_pc", instr_pc_o, 0);
        do_reset();
        cycle();
        chk("restart_req", req_count, 1);

        // Randomised traffic with redirects, stalls and stray responses.
        k_gnt_pct = 60; k_min_delay = 1; k_max_delay = 3;
        k_ready_pct = 70; k_redir_pct = 5; k_stray_pct = 10;
        repeat (3000) cycle();
        k_ready_pct = 25; k_redir_pct = 2; k_gnt_pct = 90;
        repeat (1500) cycle();
        chk("random_progress", pop_count > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction fetch unit with a prefetch buffer; generalises the stimulus-driven instruction feed into `top`.
- Fetches sequential words from instruction memory over a req/gnt/rvalid handshake and buffers up to DEPTH instructions.
- Presents instructions to decode over valid/ready, with per-entry pre-decode flags.
- Supports a branch redirect that flushes the buffer and drops any in-flight response.

Parameters:
- DATAWIDTH, 32, instruction width; opcode is bits [3:0] per the shared encoding.
- ADDRWIDTH, 16, word-address width of the PC.
- DEPTH, 4, buffer entries; power of 2, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- imem_req_o  out  1  fetch request; held until granted.
- imem_addr_o  out  ADDRWIDTH  fetch word address; stable while imem_req_o=1 and imem_gnt_i=0.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; arrives ≥1 cycle after gnt, in order.
- imem_rdata_i  in  DATAWIDTH  fetched instruction.
- redirect_i  in  1  branch taken; flush the buffer and refetch.
- redirect_pc_i  in  ADDRWIDTH  new fetch address.
- instr_valid_o  out  1  head entry valid.
- instr_ready_i  in  1  decode accepts the head entry.
- instr_o  out  DATAWIDTH  head instruction.
- instr_pc_o  out  ADDRWIDTH  head instruction address.
- instr_is_branch_o  out  1  head opcode is BEQ, BGT or BGE.
- instr_is_mem_o  out  1  head opcode is LW or SW.

Behaviour:
- Reset values (async, rst_ni=0):
  - fetch_pc=RESET_PC; FSM=IDLE; buffer empty.
  - imem_req_o=0, instr_valid_o=0; all data outputs 0.
- Buffer: circular, with log2(DEPTH) pointers plus an occupancy count of log2(DEPTH)+1 bits.
  - Push happens on an accepted rvalid; pop happens on instr_valid_o & instr_ready_i.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Credit rule:
  - At most one request is outstanding.
  - A new request is issued only when count + outstanding < DEPTH (pops in the same cycle are counted), so the buffer can never overflow.
- FSM states: IDLE, REQ, WAIT, REQ_KILL, WAIT_KILL.
  - IDLE: if credit is available and there is no redirect, go to REQ with imem_addr_o=fetch_pc.
  - REQ: imem_req_o=1.
    - gnt: fetch_pc+=1 (wraps at 2^ADDRWIDTH), go to WAIT.
    - redirect without gnt: go to REQ_KILL; the address is held.
  - WAIT: on rvalid, push {rdata, pc, flags} and go to IDLE; the next REQ can assert the following cycle.
    - redirect without rvalid: go to WAIT_KILL.
  - REQ_KILL: imem_req_o=1 with the old address; gnt goes to WAIT_KILL.
  - WAIT_KILL: rvalid is discarded (no push), go to IDLE.
- Redirect, in the same cycle as redirect_i=1:
  - count, rd_ptr and wr_ptr are cleared at the next edge.
  - fetch_pc <= redirect_pc_i.
  - instr_valid_o=0 from the next cycle.
  - A pop in the redirect cycle still completes; decode owns that instruction.
- Redirect coincident with events:
  - In WAIT with rvalid: the data is discarded and the FSM goes to IDLE.
  - In REQ with gnt: go to WAIT_KILL; fetch_pc takes redirect_pc_i, not the incremented value.
  - Redirect in IDLE: no request is issued that cycle.
- Latency:
  - First imem_req_o=1 appears in the first cycle after rst_ni rises, with addr=RESET_PC.
  - instr_valid_o rises 1 cycle after the accepted rvalid.
  - Throughput with gnt in the request cycle and rvalid the next cycle: 1 instruction per 3 cycles.
- Output registering:
  - Outputs are driven from the head entry.
  - Pre-decode flags are computed at push and stored, not recomputed at the output.
- Stray inputs: rvalid in IDLE or REQ is ignored. Reset asserted mid-transaction: the in-flight response is lost; the memory side is required to reset together with this block.

Decomposition:
- Shared package:
  - opcode constants, the same values as the existing opcode header.
  - instruction field offsets: offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
  - fetch FSM state enum.
  - buffer entry struct {instr, pc, is_branch, is_mem}.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO with a flush input, count and full/empty outputs. The FSM and credit logic stay in the parent.

Test Plan:
- Reset then imem with gnt in the same cycle and rvalid 1 cycle later returning the ADD word 0x0000_4310, instr_ready_i=1:
  - first req at addr 0;
  - instr_o=0x0000_4310, pc=0, instr_valid_o rises 1 cycle after rvalid;
  - subsequent PCs 1,2,3.
- Fill with instr_ready_i=0, DEPTH=4: exactly 4 requests (addr 0..3), no 5th request. Raise ready: pops in order, and a request for addr 4 issues once credit frees.
- Redirect to 0x0040 while in WAIT: the returning rvalid is not pushed, the buffer is empty next cycle, and the next request is at addr 0x0040.
- Redirect during REQ without gnt (gnt stalled 3 cycles): the address is held at the old value until gnt, that response is dropped, and the next request is at redirect_pc.
- Pre-decode: push BEQ, LW, ADD → is_branch/is_mem = 1/0, 0/1, 0/0. Wrap-around: 10 instructions through DEPTH=4 all arrive in order with correct PCs.
- Assert rst_ni low mid-WAIT: outputs return to reset values immediately (async). After release, fetch restarts at RESET_PC.
